// File: rtl/wb_merge_if.sv
// Writeback-merge bus: pipe request, aux handshake, both register-file write
// ports and the pending-write interlock queries.
interface wb_merge_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        RegWrite2;
  logic [4:0]  Write_register2;
  logic [31:0] Write_data2;
  logic [4:0]  q_rd1;
  logic [4:0]  q_rd2;
  logic        q_busy1;
  logic        q_busy2;

  modport master (
    output pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data, q_rd1, q_rd2,
    input  aux_ready, RegWrite, Write_register, Write_data,
           RegWrite2, Write_register2, Write_data2, q_busy1, q_busy2
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data, q_rd1, q_rd2,
    output aux_ready, RegWrite, Write_register, Write_data,
           RegWrite2, Write_register2, Write_data2, q_busy1, q_busy2
  );
endinterface

// File: rtl/wb_merge.sv
// Merges the main-pipeline writeback (registered port 1) with long-latency results
// queued in a small FIFO (port 2). Optional flush port enabled by WB_FLUSH_EN.
module wb_merge #(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
`ifdef WB_FLUSH_EN
  input  logic      flush,
`endif
  wb_merge_if.slave wb
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [4:0]       f_rd   [DEPTH];
  logic [31:0]      f_data [DEPTH];
  logic [DEPTH-1:0] f_live;
  logic             empty, full, push, pop, kill, flush_act;

`ifdef WB_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  always_comb begin
    wr_idx = wr_ptr[AW-1:0];
    rd_idx = rd_ptr[AW-1:0];
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    push   = wb.aux_valid && !full;
    pop    = !empty;
    kill   = wb.pipe_we && (wb.pipe_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      f_live            <= '0;
      wb.RegWrite       <= 1'b0;
      wb.Write_register <= '0;
      wb.Write_data     <= '0;
    end else begin
      wb.RegWrite       <= kill;
      wb.Write_register <= wb.pipe_rd;
      wb.Write_data     <= wb.pipe_data;
      if (flush_act) begin
        rd_ptr <= wr_ptr;
        f_live <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        // Live is cleared on pop too, so a set live bit always means "stored".
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (push && (AW'(i) == wr_idx)) begin
            f_rd[i]   <= wb.aux_rd;
            f_data[i] <= wb.aux_data;
            f_live[i] <= (wb.aux_rd != '0) && !(kill && (wb.aux_rd == wb.pipe_rd));
          end else if ((pop && (AW'(i) == rd_idx)) || (kill && (f_rd[i] == wb.pipe_rd))) begin
            f_live[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    wb.aux_ready       = !full;
    wb.Write_register2 = f_rd[rd_idx];
    wb.Write_data2     = f_data[rd_idx];
    wb.RegWrite2       = !empty && f_live[rd_idx] && !reset && !flush_act;
    wb.q_busy1         = 1'b0;
    wb.q_busy2         = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (f_live[i] && (f_rd[i] == wb.q_rd1)) wb.q_busy1 = 1'b1;
      if (f_live[i] && (f_rd[i] == wb.q_rd2)) wb.q_busy2 = 1'b1;
    end
    if (reset || (wb.q_rd1 == '0)) wb.q_busy1 = 1'b0;
    if (reset || (wb.q_rd2 == '0)) wb.q_busy2 = 1'b0;
  end

endmodule
